// File: rtl/gray_pkg.sv
// Shared definitions for the 3-bit gray-code sequence monitor.
package gray_pkg;

  localparam int unsigned GRAY_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_e;

  // Binary successor with natural wrap (7 -> 0).
  function automatic logic [GRAY_W-1:0] bin_succ(input logic [GRAY_W-1:0] b);
    return b + GRAY_W'(1);
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational gray-to-binary converter: each binary bit is the XOR of all gray bits at or above it.
module gray2bin
  import gray_pkg::*;
(
  input  logic [GRAY_W-1:0] gray,
  output logic [GRAY_W-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < GRAY_W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_monitor.sv
// Converts an upstream gray counter to binary, checks that it only stalls or steps by one,
// and counts completed 7 -> 0 wraps.
module gray_monitor
  import gray_pkg::*;
#(
  parameter int unsigned LAP_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              En,
  input  logic              Clr,
  input  logic [GRAY_W-1:0] Gray,
  output logic [GRAY_W-1:0] Binary,
  output logic              Valid,
  output logic              Step_err,
  output logic [LAP_W-1:0]  Laps
);

  logic [GRAY_W-1:0] sample;

  state_e            state_q, state_d;
  logic [GRAY_W-1:0] ref_q, ref_d;
  logic [GRAY_W-1:0] bin_q, bin_d;
  logic [LAP_W-1:0]  laps_q, laps_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  gray2bin u_gray2bin (
    .gray (Gray),
    .bin  (sample)
  );

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    bin_d   = bin_q;
    laps_d  = laps_q;
    valid_d = 1'b0;
    err_d   = err_q;

    // Clear wins over a same-cycle sample, which is dropped.
    if (Clr) begin
      state_d = IDLE;
      ref_d   = '0;
      laps_d  = '0;
      err_d   = 1'b0;
    end else if (En) begin
      bin_d   = sample;
      ref_d   = sample;
      valid_d = 1'b1;
      unique case (state_q)
        IDLE: begin
          state_d = TRACK;
        end
        TRACK: begin
          if (sample == ref_q) begin
            state_d = TRACK;
          end else if (sample == bin_succ(ref_q)) begin
            if ((ref_q == '1) && (laps_q != '1)) begin
              laps_d = laps_q + LAP_W'(1);
            end
          end else begin
            err_d   = 1'b1;
            state_d = FAULT;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      ref_q   <= '0;
      bin_q   <= '0;
      laps_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      bin_q   <= bin_d;
      laps_q  <= laps_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign Binary   = bin_q;
  assign Valid    = valid_q;
  assign Step_err = err_q;
  assign Laps     = laps_q;

endmodule

// File: tb/tb_gray_monitor.sv
// Scoreboard bench for gray_monitor: an 8-bit and a 2-bit lap instance share stimulus.
module tb_gray_monitor;
  import gray_pkg::*;

  typedef struct packed {
    logic [2:0] bin;
    logic       err;
    logic [7:0] l8;
    logic [1:0] l2;
  } exp_t;

  logic              Clk;
  logic              Reset;
  logic              En;
  logic              Clr;
  logic [GRAY_W-1:0] Gray;
  logic [GRAY_W-1:0] bin8, bin2;
  logic              valid8, valid2;
  logic              err8, err2;
  logic [7:0]        laps8;
  logic [1:0]        laps2;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [2:0] codes [0:7] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  gray_monitor #(.LAP_W(8)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .En       (En),
    .Clr      (Clr),
    .Gray     (Gray),
    .Binary   (bin8),
    .Valid    (valid8),
    .Step_err (err8),
    .Laps     (laps8)
  );

  gray_monitor #(.LAP_W(2)) dut2 (
    .Clk      (Clk),
    .Reset    (Reset),
    .En       (En),
    .Clr      (Clr),
    .Gray     (Gray),
    .Binary   (bin2),
    .Valid    (valid2),
    .Step_err (err2),
    .Laps     (laps2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every Valid pulse consumes one expected entry.
  always @(negedge Clk) begin
    exp_t e;
    if (valid8 === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got 1 expected 0 at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("binary", 32'(bin8), 32'(e.bin));
        chk("step_err", 32'(err8), 32'(e.err));
        chk("laps", 32'(laps8), 32'(e.l8));
        chk("valid_w2", 32'(valid2), 32'd1);
        chk("binary_w2", 32'(bin2), 32'(e.bin));
        chk("step_err_w2", 32'(err2), 32'(e.err));
        chk("laps_w2", 32'(laps2), 32'(e.l2));
      end
    end else if (valid2 === 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL valid_w2_alone: got 1 expected 0 at %0t", $time);
    end
  end

  task automatic smp(input logic [2:0] g, input logic [2:0] b, input logic err,
                     input logic [7:0] l8, input logic [1:0] l2);
    exp_t e;
    @(negedge Clk);
    Reset = 1'b1;
    Clr   = 1'b0;
    En    = 1'b1;
    Gray  = g;
    e.bin = b;
    e.err = err;
    e.l8  = l8;
    e.l2  = l2;
    q.push_back(e);
  endtask

  task automatic quiet();
    @(negedge Clk);
    En  = 1'b0;
    Clr = 1'b0;
  endtask

  // Legal lap from binary 0: samples 1..7 then the wrap to 0.
  task automatic lap(input logic [7:0] l8o, input logic [1:0] l2o, input logic [7:0] l8n,
                     input logic [1:0] l2n, input logic err);
    for (int i = 1; i < 8; i++) smp(codes[i], 3'(i), err, l8o, l2o);
    smp(3'b000, 3'd0, err, l8n, l2n);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_binary"}, 32'(bin8), 32'd0);
    chk({tag, "_valid"}, 32'(valid8), 32'd0);
    chk({tag, "_step_err"}, 32'(err8), 32'd0);
    chk({tag, "_laps"}, 32'(laps8), 32'd0);
    chk({tag, "_laps_w2"}, 32'(laps2), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held two cycles with a live sample on the bus.
    Reset = 1'b0;
    Clr   = 1'b0;
    En    = 1'b1;
    Gray  = 3'b011;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk_idle("reset");
    Reset = 1'b1;
    En    = 1'b0;

    // One full legal lap from IDLE.
    smp(3'b000, 3'd0, 1'b0, 8'd0, 2'd0);
    lap(8'd0, 2'd0, 8'd1, 2'd1, 1'b0);

    // Stalls are accepted without error.
    smp(3'b001, 3'd1, 1'b0, 8'd1, 2'd1);
    smp(3'b011, 3'd2, 1'b0, 8'd1, 2'd1);
    smp(3'b011, 3'd2, 1'b0, 8'd1, 2'd1);
    smp(3'b011, 3'd2, 1'b0, 8'd1, 2'd1);
    smp(3'b010, 3'd3, 1'b0, 8'd1, 2'd1);
    quiet();

    // Further wraps: 2-bit counter saturates at 3.
    smp(3'b110, 3'd4, 1'b0, 8'd1, 2'd1);
    smp(3'b111, 3'd5, 1'b0, 8'd1, 2'd1);
    smp(3'b101, 3'd6, 1'b0, 8'd1, 2'd1);
    smp(3'b100, 3'd7, 1'b0, 8'd1, 2'd1);
    smp(3'b000, 3'd0, 1'b0, 8'd2, 2'd2);
    lap(8'd2, 2'd2, 8'd3, 2'd3, 1'b0);
    lap(8'd3, 2'd3, 8'd4, 2'd3, 1'b0);
    lap(8'd4, 2'd3, 8'd5, 2'd3, 1'b0);
    quiet();

    // Skip 1 -> 3 faults; later legal laps do not count.
    smp(3'b000, 3'd0, 1'b0, 8'd5, 2'd3);
    smp(3'b001, 3'd1, 1'b0, 8'd5, 2'd3);
    smp(3'b010, 3'd3, 1'b1, 8'd5, 2'd3);
    smp(3'b110, 3'd4, 1'b1, 8'd5, 2'd3);
    smp(3'b111, 3'd5, 1'b1, 8'd5, 2'd3);
    smp(3'b101, 3'd6, 1'b1, 8'd5, 2'd3);
    smp(3'b100, 3'd7, 1'b1, 8'd5, 2'd3);
    smp(3'b000, 3'd0, 1'b1, 8'd5, 2'd3);
    lap(8'd5, 2'd3, 8'd5, 2'd3, 1'b1);
    quiet();

    // Clear with a same-cycle sample: sample dropped, state back to IDLE.
    @(negedge Clk);
    Clr  = 1'b1;
    En   = 1'b1;
    Gray = 3'b110;
    @(negedge Clk);
    Clr = 1'b0;
    En  = 1'b0;
    chk_idle("clr");

    // IDLE accepts 111 unchecked; then upstream reset 6 -> 0 is a fault.
    smp(3'b111, 3'd5, 1'b0, 8'd0, 2'd0);
    smp(3'b101, 3'd6, 1'b0, 8'd0, 2'd0);
    smp(3'b000, 3'd0, 1'b1, 8'd0, 2'd0);
    smp(3'b001, 3'd1, 1'b1, 8'd0, 2'd0);
    quiet();

    // Reset beats Clr and En in the same cycle.
    @(negedge Clk);
    Reset = 1'b0;
    Clr   = 1'b1;
    En    = 1'b1;
    Gray  = 3'b001;
    @(negedge Clk);
    Reset = 1'b1;
    Clr   = 1'b0;
    En    = 1'b0;
    chk_idle("reset_prio");
    smp(3'b010, 3'd3, 1'b0, 8'd0, 2'd0);
    smp(3'b110, 3'd4, 1'b0, 8'd0, 2'd0);
    quiet();

    repeat (3) @(negedge Clk);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_monitor.md
GRAY_MONITOR -- requirements
Module: gray_monitor

Interface
REQ-001 SHALL have parameter: LAP_W, 8, width of lap counter.
REQ-002 SHALL have port: Clk  input  1  system clock, all state updates on posedge.
REQ-003 SHALL have port: Reset  input  1  synchronous active-low reset (0 = reset).
REQ-004 SHALL have port: En  input  1  sample strobe; Gray is valid this cycle.
REQ-005 SHALL have port: Clr  input  1  synchronous clear of error, laps and tracking state.
REQ-006 SHALL have port: Gray  input  3  gray code from upstream 3-bit gray counter.
REQ-007 SHALL have port: Binary  output  3  registered binary equivalent of last accepted sample.
REQ-008 SHALL have port: Valid  output  1  one-cycle pulse: Binary updated from a sample.
REQ-009 SHALL have port: Step_err  output  1  sticky sequence-violation flag.
REQ-010 SHALL have port: Laps  output  LAP_W  count of completed wraps (binary 7 -> 0), saturating.

Function
REQ-011 SHALL convert gray to binary as b2=g2, b1=g2^g1, b0=b1^g0 (000,001,011,010,110,111,101,100 -> 0..7).
REQ-012 SHALL register Binary and Valid one cycle after an En sample; Valid SHALL be 0 in cycles with no accepted sample.
REQ-013 SHALL implement states IDLE (no reference sample), TRACK, FAULT.
REQ-014 IDLE: on En, SHALL capture the sample as reference, update Binary, pulse Valid, go TRACK; no step check, no lap count.
REQ-015 TRACK, En with new binary == previous: SHALL treat as stall; update Binary, pulse Valid, no error, no lap.
REQ-016 TRACK, En with new binary == (previous+1) mod 8: SHALL accept; if previous==7 and new==0, Laps SHALL increment.
REQ-017 TRACK, En with any other value: SHALL set Step_err in the same cycle Valid pulses for that sample, go FAULT.
REQ-018 FAULT: SHALL keep converting (Binary, Valid update on En), SHALL NOT change Laps, Step_err stays 1.
REQ-019 FAULT SHALL be left only via Clr or Reset.
REQ-020 Laps SHALL saturate at 2^LAP_W-1 and never wrap.
REQ-021 Clr=1 SHALL, next cycle, give Step_err=0, Laps=0, Valid=0, state IDLE; an En sample in the same cycle SHALL be ignored.
REQ-022 Reference sample SHALL update on every accepted En sample in every state.
REQ-023 Without Clr, an upstream reset mid-sequence (jump to 000 from a non-7 value) SHALL be flagged as a step error.

Reset
REQ-024 Reset=0 at a Clk edge SHALL set Binary=0, Valid=0, Step_err=0, Laps=0, state IDLE, reference=0.
REQ-025 Reset SHALL take priority over Clr and En in the same cycle.
REQ-026 Reset SHALL be sampled only on the clock edge; no asynchronous paths.

Structure
REQ-027 Shared package gray_pkg SHALL hold GRAY_W=3 and state encodings IDLE/TRACK/FAULT.
REQ-028 Gray-to-binary conversion SHALL be a combinational sub-module gray2bin (3-bit in, 3-bit out).
REQ-029 State, reference, Laps and outputs SHALL be in one clocked process; next-state logic combinational.

Verification
REQ-030 Reset=0 for 2 cycles with En=1, Gray=011 -> Binary=0, Valid=0, Step_err=0, Laps=0.
REQ-031 En=1 every cycle, Gray 000,001,011,010,110,111,101,100,000 -> Binary 0..7,0; Laps=1 after 9th sample; Step_err=0.
REQ-032 Gray 001,011,011,011,010 -> Valid pulses 5 times, Binary 1,2,2,2,3, Step_err=0.
REQ-033 Gray 000,001,010 -> Step_err=1 with Binary=3; then full legal lap -> Laps unchanged, Step_err stays 1.
REQ-034 Clr=1 and En=1 (Gray=110) same cycle in FAULT -> next cycle Step_err=0, Laps=0, Valid=0; next sample 111 accepted without check.
REQ-035 LAP_W=2, 5 legal wraps -> Laps=1,2,3,3,3.
